// File: rtl/clock_enable_scheduler_pkg.sv
// clock_enable_scheduler_pkg: shared mode/state encodings and reset divisor for the clock enable scheduler
package clock_enable_scheduler_pkg;
    typedef enum logic [1:0] {
        MODE_STOP    = 2'b00,
        MODE_RUN     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_ONESHOT = 2'b10
    } state_e;
    localparam int unsigned DEF_DIVISOR = 4_000_000;
    // Reserved mode behaves as stop.
    function automatic state_e mode_to_state(input logic [1:0] mode);
        return mode == MODE_RUN ? ST_RUN : mode == MODE_ONESHOT ? ST_ONESHOT : ST_IDLE;
    endfunction
endpackage

// File: rtl/clock_enable_channel.sv
// clock_enable_channel: one programmable divider channel with pending slot and period-boundary updates
// clock_in/reset: fabric clock, sync active-high reset
// cfg_load: accepted non-zero config for this channel; cfg_divisor/cfg_mode: its payload
// sync_restart: realign counter to 0 if running
// pending: an update is waiting for the boundary; tick/wave/busy: decoded enables
module clock_enable_channel
    import clock_enable_scheduler_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 28,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_DIVISOR = CNT_WIDTH'(DEF_DIVISOR)
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 cfg_load,
    input  logic [CNT_WIDTH-1:0] cfg_divisor,
    input  logic [1:0]           cfg_mode,
    input  logic                 sync_restart,
    output logic                 pending,
    output logic                 tick,
    output logic                 wave,
    output logic                 busy
);
    state_e               state, state_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx, div, div_nx, pdiv, pdiv_nx, adiv;
    logic [1:0]           pmode, pmode_nx, amode;
    logic                 pend_nx, apply;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            div     <= DEFAULT_DIVISOR;
            pending <= 1'b0;
            pdiv    <= '0;
            pmode   <= MODE_STOP;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            div     <= div_nx;
            pending <= pend_nx;
            pdiv    <= pdiv_nx;
            pmode   <= pmode_nx;
        end
    end

    // A config accepted on the boundary/restart cycle itself is applied right away,
    // so a finished one-shot never strands an update in the pending slot.
    always_comb begin
        adiv     = pending ? pdiv : cfg_divisor;
        amode    = pending ? pmode : cfg_mode;
        apply    = busy ? (sync_restart || tick) && (pending || cfg_load) : cfg_load;
        state_nx = state;
        cnt_nx   = cnt;
        div_nx   = div;
        pend_nx  = pending;
        pdiv_nx  = pdiv;
        pmode_nx = pmode;
        if (apply) begin
            state_nx = mode_to_state(amode);
            cnt_nx   = '0;
            div_nx   = adiv;
            pend_nx  = 1'b0;
        end else if (busy && (sync_restart || tick)) begin
            cnt_nx   = '0;
            state_nx = (tick && !sync_restart && state == ST_ONESHOT) ? ST_IDLE : state;
        end else if (busy) begin
            cnt_nx   = cnt + 1'b1;
            pend_nx  = pending || cfg_load;
            pdiv_nx  = cfg_load ? cfg_divisor : pdiv;
            pmode_nx = cfg_load ? cfg_mode : pmode;
        end
    end

    always_comb begin
        busy = state != ST_IDLE;
        tick = busy && cnt == div - 1'b1;
        wave = busy && cnt < (div >> 1);
    end
endmodule

// File: rtl/clock_enable_scheduler.sv
// clock_enable_scheduler: NUM_CH runtime-programmable tick/square-wave enable generators
// clock_in/reset: fabric clock, sync active-high reset
// cfg_valid/cfg_ready/cfg_ch/cfg_divisor/cfg_mode: per-channel config handshake; cfg_err: zero-divisor reject pulse
// sync_restart: realign running channels; tick_out/wave_out/busy: per-channel outputs
module clock_enable_scheduler
    import clock_enable_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_WIDTH = 28,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_DIVISOR = CNT_WIDTH'(DEF_DIVISOR),
    parameter int unsigned CH_W = 2
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_divisor,
    input  logic [1:0]           cfg_mode,
    output logic                 cfg_err,
    input  logic                 sync_restart,
    output logic [NUM_CH-1:0]    tick_out,
    output logic [NUM_CH-1:0]    wave_out,
    output logic [NUM_CH-1:0]    busy
);
    logic [NUM_CH-1:0]      pending;
    logic [(1<<CH_W)-1:0]   pend_all;
    logic                   xfer;

    // Channel indices beyond NUM_CH read as permanently pending, so they never accept.
    always_comb begin
        pend_all              = '1;
        pend_all[NUM_CH-1:0]  = pending;
        cfg_ready             = !pend_all[cfg_ch];
        xfer                  = cfg_valid && cfg_ready;
    end

    always_ff @(posedge clock_in) begin
        if (reset)
            cfg_err <= 1'b0;
        else
            cfg_err <= xfer && cfg_divisor == '0;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_enable_channel #(
            .CNT_WIDTH(CNT_WIDTH),
            .DEFAULT_DIVISOR(DEFAULT_DIVISOR)
        ) u_ch (
            .clock_in(clock_in),
            .reset(reset),
            .cfg_load(xfer && cfg_ch == CH_W'(i) && cfg_divisor != '0),
            .cfg_divisor(cfg_divisor),
            .cfg_mode(cfg_mode),
            .sync_restart(sync_restart),
            .pending(pending[i]),
            .tick(tick_out[i]),
            .wave(wave_out[i]),
            .busy(busy[i])
        );
    end
endmodule

// File: tb/tb_clock_enable_scheduler.sv
// tb_clock_enable_scheduler: directed + random stimulus checked against a period-timing reference model
module tb_clock_enable_scheduler;
    localparam int NUM_CH = 4;
    localparam int DEF = 4_000_000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = '0;
    logic [27:0] cfg_divisor = '0;
    logic [1:0]  cfg_mode = '0;
    logic        cfg_err;
    logic        sync_restart = 1'b0;
    logic [3:0]  tick_out, wave_out, busy;

    clock_enable_scheduler #(.NUM_CH(4), .CNT_WIDTH(28), .CH_W(2)) dut (
        .clock_in(clk), .reset(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_divisor(cfg_divisor), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
        .sync_restart(sync_restart), .tick_out(tick_out), .wave_out(wave_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int now = 0;
    bit armed = 0;

    // Reference model: each channel is described by when its current period began and its length.
    bit m_act[NUM_CH];
    bit m_one[NUM_CH];
    int m_start[NUM_CH];
    int m_div[NUM_CH];
    bit m_pend[NUM_CH];
    int m_pdiv[NUM_CH];
    int m_pmode[NUM_CH];
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, now);
        end
    endtask

    function automatic int pos(input int i);
        return now - m_start[i];
    endfunction

    task automatic load(input int i, input int d, input int md);
        m_div[i]   = d;
        m_act[i]   = (md == 1 || md == 2);
        m_one[i]   = (md == 2);
        m_start[i] = now + 1;
        m_pend[i]  = 0;
    endtask

    task automatic model_step(input logic v, input int ch, input int d, input int md,
                              input logic rs, input logic r);
        bit rdy, acc;
        if (r) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_act[i] = 0; m_one[i] = 0; m_start[i] = 0; m_div[i] = DEF; m_pend[i] = 0;
            end
            m_err = 0;
            return;
        end
        rdy = !m_pend[ch];
        m_err = v && rdy && d == 0;
        acc = v && rdy && d != 0;
        for (int i = 0; i < NUM_CH; i++) begin
            bit me;
            me = acc && ch == i;
            if (!m_act[i]) begin
                if (me) load(i, d, md);
            end else if (rs || pos(i) == m_div[i] - 1) begin
                if (m_pend[i]) load(i, m_pdiv[i], m_pmode[i]);
                else if (me) load(i, d, md);
                else if (!rs && m_one[i]) m_act[i] = 0;
                else m_start[i] = now + 1;
            end else if (me) begin
                m_pend[i] = 1; m_pdiv[i] = d; m_pmode[i] = md;
            end
        end
    endtask

    task automatic cyc(input logic v, input int ch, input int d, input int md,
                       input logic rs, input logic r);
        logic [3:0] et, ew, eb;
        @(negedge clk);
        if (armed) begin
            for (int i = 0; i < NUM_CH; i++) begin
                et[i] = m_act[i] && pos(i) == m_div[i] - 1;
                ew[i] = m_act[i] && pos(i) < m_div[i] / 2;
                eb[i] = m_act[i];
            end
            check("tick_out", 32'(tick_out), 32'(et));
            check("wave_out", 32'(wave_out), 32'(ew));
            check("busy", 32'(busy), 32'(eb));
            check("cfg_err", 32'(cfg_err), 32'(m_err));
        end
        cfg_valid = v;
        cfg_ch = ch[1:0];
        cfg_divisor = 28'(d);
        cfg_mode = md[1:0];
        sync_restart = rs;
        rst = r;
        #1;
        if (armed) check("cfg_ready", 32'(cfg_ready), 32'(!m_pend[ch]));
        model_step(v, ch, d, md, rs, r);
        now++;
        if (r) armed = 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_pos(input int ch, input int p);
        int k;
        for (k = 0; k < 40 && !(m_act[ch] && pos(ch) == p); k++) idle(1);
        if (k == 40) check("wait_pos", 32'(pos(ch)), 32'(p));
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        idle(2);
        cyc(1, 0, 4, 1, 0, 0);
        idle(12);
        cyc(1, 1, 5, 1, 0, 0);
        idle(15);
        wait_pos(0, 1);
        cyc(1, 0, 6, 1, 0, 0);
        cyc(1, 0, 7, 1, 0, 0);
        idle(20);
        cyc(1, 2, 3, 2, 0, 0);
        idle(22);
        cyc(1, 3, 0, 1, 0, 0);
        idle(6);
        begin
            int k;
            for (k = 0; k < 60 && !(pos(0) == 2 && pos(1) == 3); k++) idle(1);
        end
        cyc(0, 0, 0, 0, 1, 0);
        idle(8);
        wait_pos(0, 1);
        cyc(1, 0, 7, 1, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 1);
        idle(6);
        for (int n = 0; n < 2500; n++) begin
            int d;
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 9));
            cyc($urandom_range(0, 9) < 3, int'($urandom_range(0, 3)), d,
                int'($urandom_range(0, 3)), $urandom_range(0, 24) == 0,
                $urandom_range(0, 299) == 0);
        end
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/clock_enable_scheduler.md
Name: clock_enable_scheduler

Overview:
- Runtime-programmable scheduler for divided clock enables, replacing fixed-DIVISOR dividers where firmware must retune rates.
- Runs NUM_CH independent channels from the one fabric clock.
- Each channel produces a single-cycle tick enable and a square-wave enable, using the same duty rule as the existing dividers.
- A config handshake loads divisor and mode per channel. Updates to running channels are applied glitch-free at period boundaries.

Parameters:
- NUM_CH, 4, number of channels (2..8)
- CNT_WIDTH, 28, counter/divisor width
- DEFAULT_DIVISOR, 28'd4_000_000, divisor loaded at reset
- CH_W, 2, width of cfg_ch; must equal clog2(NUM_CH)

Ports:
- clock_in  in  1  fabric clock
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config may be accepted for channel cfg_ch
- cfg_ch  in  CH_W  target channel
- cfg_divisor  in  CNT_WIDTH  new divisor
- cfg_mode  in  2  00 stop, 01 free-run, 10 one-shot, 11 reserved (treated as stop)
- cfg_err  out  1  one-cycle pulse: request rejected
- sync_restart  in  1  realign all running channels
- tick_out  out  NUM_CH  one-cycle pulse at end of each period
- wave_out  out  NUM_CH  divided square wave
- busy  out  NUM_CH  channel running

Behaviour:
- Decided: one clock, clock_in. Reset is synchronous, active-high, on port reset.
- Reset: every channel goes to IDLE, counter 0, divisor=DEFAULT_DIVISOR, pending clear. tick_out=0, wave_out=0, busy=0, cfg_err=0, cfg_ready=1 from the next cycle. Reset mid-operation discards pending updates.
- Per-channel states:
  - IDLE: busy=0; outputs 0.
  - RUN: free-running.
  - ONESHOT: one period, then IDLE.
- Counter sequence: 0..div-1, then wraps to 0.
- Outputs are decoded from registered state only; there is no combinational path from inputs to outputs.
  - tick_out[i]=1 exactly while counter==div-1 in RUN/ONESHOT.
  - wave_out[i]=1 while counter < div/2 (floor) in RUN/ONESHOT.
  - Odd divisors are therefore low-biased: div=5 gives high 2, low 3.
  - div=1: tick every cycle, wave constant 0.
- Handshake: cfg_ready = !pending[cfg_ch]. A transfer occurs when cfg_valid && cfg_ready.
  - cfg_divisor==0 is rejected: cfg_err pulses the next cycle and no state changes.
  - A valid request to an IDLE channel is applied the next cycle: counter=0, new divisor, state per mode. cfg_mode 00 or 11 on an IDLE channel only updates the stored divisor.
  - A valid request to a RUN/ONESHOT channel is stored in the pending slot.
- Boundary update: on the cycle after a running channel's counter==div-1:
  - If pending: apply it (counter=0, new divisor, new state; stop gives IDLE), then clear pending.
  - Else RUN wraps to 0, and ONESHOT goes to IDLE.
- No partial periods are ever emitted.
- sync_restart (one cycle): next cycle every RUN/ONESHOT channel has counter=0.
  - Pending entries, including a config accepted in the same cycle, are applied at that restart.
  - sync_restart beats terminal count: no extra boundary action occurs and no tick is suppressed retroactively.
  - IDLE channels are unaffected.
- Only one config is accepted per cycle. Other channels continue undisturbed.

Decomposition:
- Shared package / include:
  - mode encodings MODE_STOP/MODE_RUN/MODE_ONESHOT
  - state encodings ST_IDLE/ST_RUN/ST_ONESHOT
  - default divisor constant
- Sub-module clock_enable_channel holds one channel's counter, divisor, pending slot, FSM and output decode.
- The top-level module handles cfg_ch decode, cfg_ready mux, cfg_err and generate-loop instantiation.

Test Plan:
- Reset, then cfg ch0 div=4 mode 01:
  - busy[0] rises 1 cycle after accept.
  - wave_out[0] pattern 1,1,0,0 repeating.
  - tick_out[0] on every 4th cycle, aligned with the last 0.
- ch1 div=5 free-run: wave 1,1,0,0,0 and tick period 5. ch0 (div 4) runs concurrently, unaffected.
- ch0 running div=4; at counter=1 write div=6:
  - cfg_ready[ch0] drops until the boundary.
  - The current period ends at 4 cycles, then periods of 6 with wave 1,1,1,0,0,0.
  - A second write while pending is refused (not accepted).
- ch2 one-shot div=3: exactly one tick 3 cycles after start, then busy[2]=0 and wave 0; no further ticks over 20 cycles.
- Error and restart:
  - cfg_divisor=0 gives a cfg_err pulse and unchanged behaviour.
  - sync_restart with ch0 at counter=2 and ch1 at counter=3: both channels show counter 0 next cycle and wave high.
- Reset asserted mid-period with a pending update: all outputs 0 next cycle, pending lost, divisor reverts to 4_000_000.
